baud_gen_frac: RTL and testbench

Parametrised UART baud generator with a runtime-programmable divisor, optional fractional correction and an oversampling stage. From the system clock it produces single-cycle oversample strobes (`sample_tick`), mid-bit strobes (`mid_tick`) and bit-boundary strobes (`bit_tick`). It feeds both the UART transmitter (bit timing) and the receiver (oversampled start-bit detection and mid-bit sampling). It replaces the fixed four-rate toggling generator: strobes are pulses, not a square wave, and the rate is a register rather than a 2-bit select.

---
 rtl/baud_gen_frac.sv | 178 +++++++++++++++++
 tb/tb_baud_gen_frac.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: UART baud generator, programmable divisor, oversampled strobes.
// Optional fractional correction is built only when BAUD_FRAC_EN is defined.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   en               - run enable; low holds the generator idle and re-armed
//   div_int/div_frac - new divisor, captured by the div_load strobe
//   load_pending     - a captured divisor waits for the next bit boundary
//   sample_tick      - one pulse per oversample period
//   mid_tick/bit_tick- pulses on sample OVS/2 and sample OVS of each bit
//   ovs_phase        - sample ticks already taken in the current bit
module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int DEF_DIV_INT  = 27,
  parameter int DEF_DIV_FRAC = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    load_pending,
  output logic                    sample_tick,
  output logic                    mid_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  ovs_phase
);

  localparam int PH_W = $clog2(OVS);
  localparam int CW   = DIV_W + 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] pend_int_q, pend_int_d;
  logic             pend_v_q, pend_v_d;
  logic             st_q, st_d;
  logic             mid_q, mid_d;
  logic             bit_q, bit_d;

  logic [DIV_W-1:0] new_int_w;
  logic             ev_w;
  logic             wrap_w;
  logic             apply_w;
  logic             cap_w;
  logic             idle_ld_w;
  logic             carry_w;

  // A zero divisor would stall the counter; run it as 1.
  assign new_int_w = (div_int == '0) ? DIV_W'(1) : div_int;

  assign ev_w      = en && (cnt_q == '0);
  assign wrap_w    = ev_w && (phase_q == PH_LAST);
  // A load arriving on the wrap itself goes straight to the boundary.
  assign apply_w   = wrap_w && (div_load || pend_v_q);
  assign cap_w     = en && div_load && !wrap_w;
  assign idle_ld_w = !en && div_load;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W:0]   sum_w;

  assign sum_w   = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign carry_w = sum_w[FRAC_W];

  always_comb begin
    acc_d       = acc_q;
    act_frac_d  = act_frac_q;
    pend_frac_d = pend_frac_q;
    if (!en || apply_w) begin
      acc_d = '0;
    end else if (ev_w) begin
      acc_d = sum_w[FRAC_W-1:0];
    end
    if (idle_ld_w) begin
      act_frac_d = div_frac;
    end else if (apply_w) begin
      act_frac_d = div_load ? div_frac : pend_frac_q;
    end
    if (cap_w) begin
      pend_frac_d = div_frac;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      act_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_frac_q <= '0;
    end else begin
      acc_q       <= acc_d;
      act_frac_q  <= act_frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end
`else
  logic unused_frac;

  assign carry_w     = 1'b0;
  assign unused_frac = ^div_frac ^ (DEF_DIV_FRAC != 0);
`endif

  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    act_int_d  = act_int_q;
    pend_int_d = pend_int_q;
    pend_v_d   = pend_v_q;
    st_d       = ev_w;
    mid_d      = ev_w && (phase_q == PH_MID);
    bit_d      = wrap_w;

    if (idle_ld_w) begin
      act_int_d = new_int_w;
      pend_v_d  = 1'b0;
    end else if (apply_w) begin
      act_int_d = div_load ? new_int_w : pend_int_q;
      pend_v_d  = 1'b0;
    end
    if (cap_w) begin
      pend_int_d = new_int_w;
      pend_v_d   = 1'b1;
    end

    // Idle keeps the counter armed with whatever divisor will run next.
    if (!en) begin
      cnt_d   = {1'b0, act_int_d} - CW'(1);
      phase_d = '0;
    end else if (apply_w) begin
      cnt_d = {1'b0, act_int_d} - CW'(1);
    end else if (ev_w) begin
      cnt_d = {1'b0, act_int_q} - CW'(1) + CW'(carry_w);
    end else begin
      cnt_d = cnt_q - CW'(1);
    end

    if (ev_w) begin
      phase_d = wrap_w ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= CW'(DEF_DIV_INT - 1);
      phase_q    <= '0;
      act_int_q  <= DIV_W'(DEF_DIV_INT);
      pend_int_q <= '0;
      pend_v_q   <= 1'b0;
      st_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      act_int_q  <= act_int_d;
      pend_int_q <= pend_int_d;
      pend_v_q   <= pend_v_d;
      st_q       <= st_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
    end
  end

  assign load_pending = pend_v_q;
  assign sample_tick  = st_q;
  assign mid_tick     = mid_q;
  assign bit_tick     = bit_q;
  assign ovs_phase    = phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: scoreboard bench for baud_gen_frac.
// Expected strobes are queued as stimulus is driven, then matched to DUT output.
module tb_baud_gen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              load_pending;
  logic              sample_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic [1:0]        ovs_phase;

  typedef struct packed {
    int         c;
    logic       st;
    logic [1:0] ph;
    logic       md;
    logic       bt;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  baud_gen_frac #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .OVS(OVS),
    .DEF_DIV_INT(27),
    .DEF_DIV_FRAC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .div_int(div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .load_pending(load_pending),
    .sample_tick(sample_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .ovs_phase(ovs_phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t o;
    if (sample_tick === 1'b1 || mid_tick === 1'b1 || bit_tick === 1'b1) begin
      o.c  = cyc;
      o.st = sample_tick;
      o.ph = ovs_phase;
      o.md = mid_tick;
      o.bt = bit_tick;
      obs_q.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input int c, input int k);
    ev_t e;
    e.c  = c;
    e.st = 1'b1;
    e.ph = 2'(k % 4);
    e.md = (k % 4 == 2);
    e.bt = (k % 4 == 0);
    return e;
  endfunction

  task automatic idle_load(input int d, input int f);
    en = 1'b0;
    @(negedge clk);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    int  s;
    ev_t e, o;
    reset    = 1'b1;
    en       = 1'b1;
    div_int  = DIV_W'(5);
    div_load = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sample_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_sample: got %b want 0", sample_tick);
    end
    n_cmp++;
    if (mid_tick !== 1'b0 || bit_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_bit: got %b%b want 00", mid_tick, bit_tick);
    end
    n_cmp++;
    if (ovs_phase !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_phase: got %0d want 0", ovs_phase);
    end
    n_cmp++;
    if (load_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pending: got %b want 0", load_pending);
    end
    reset    = 1'b0;
    div_load = 1'b0;
    obs_q.delete();
    exp_q.delete();
    s = cyc;
    exp_q.push_back(mk(s + 27, 1));
    exp_q.push_back(mk(s + 54, 2));
    for (int c = 1; c <= 59; c++) begin
      @(negedge clk);
      if (c == 56) en = 1'b0;
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rst_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rst_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_basic;
    int  s;
    ev_t e, o;
    idle_load(4, 0);
    s  = cyc;
    en = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 4 * k, k));
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 18) en = 1'b0;
      if (c == 6) begin
        n_cmp++;
        if (load_pending !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_pending: got %b want 0", load_pending);
        end
      end
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_frac;
    int  s, t, acc, span, want_span;
    ev_t e, o;
    idle_load(3, 8);
    s   = cyc;
    en  = 1'b1;
    acc = 0;
    t   = s + 3;
    exp_q.push_back(mk(t, 1));
    for (int k = 2; k <= 1000; k++) begin
`ifdef BAUD_FRAC_EN
      acc = acc + 8;
      t   = t + 3 + (acc >= 16 ? 1 : 0);
      acc = acc % 16;
`else
      t = t + 3;
`endif
      exp_q.push_back(mk(t, k));
    end
`ifdef BAUD_FRAC_EN
    want_span = 3499;
`else
    want_span = 3000;
`endif
    for (int c = 1; c <= want_span + 4; c++) begin
      @(negedge clk);
      if (c == want_span) en = 1'b0;
    end
    #1;
    n_cmp++;
    span = (obs_q.size() >= 1000) ? obs_q[999].c - s : -1;
    if (span != want_span) begin
      n_bad++;
      $display("FAIL frac_span: got %0d want %0d", span, want_span);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL frac_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL frac_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_load_pending(input bit twice);
    int  s, nd, last;
    ev_t e, o;
    idle_load(4, 0);
    nd   = twice ? 8 : 6;
    last = 16 + 4 * nd;
    s    = cyc;
    en   = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 4 * k, k));
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 16 + nd * k, k));
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      if (c == last) en = 1'b0;
      if (c == 9) begin
        div_int  = DIV_W'(6);
        div_load = 1'b1;
      end
      if (c == 10) div_load = 1'b0;
      if (c == 11 && twice) begin
        div_int  = DIV_W'(8);
        div_load = 1'b1;
      end
      if (c == 12) div_load = 1'b0;
      if (c == 10 || c == 15) begin
        n_cmp++;
        if (load_pending !== 1'b1) begin
          n_bad++;
          $display("FAIL pend_high: cycle %0d got %b want 1", c, load_pending);
        end
      end
      if (c == 16) begin
        n_cmp++;
        if (load_pending !== 1'b0) begin
          n_bad++;
          $display("FAIL pend_low: got %b want 0", load_pending);
        end
      end
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL pend_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL pend_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_wrap_load;
    int  s;
    bit  seen;
    ev_t e, o;
    idle_load(4, 0);
    s    = cyc;
    en   = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 4 * k, k));
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 16 + 6 * k, k));
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      if (load_pending !== 1'b0) seen = 1'b1;
      if (c == 15) begin
        div_int  = DIV_W'(6);
        div_load = 1'b1;
      end
      if (c == 16) div_load = 1'b0;
      if (c == 40) en = 1'b0;
    end
    #1;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_pending: got %b want 0", seen);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL wrap_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_en_gap;
    int  s;
    ev_t e, o;
    idle_load(4, 0);
    s  = cyc;
    en = 1'b1;
    exp_q.push_back(mk(s + 4, 1));
    exp_q.push_back(mk(s + 8, 2));
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(s + 13 + 4 * k, k));
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 10) en = 1'b0;
      if (c == 13) en = 1'b1;
      if (c == 29) en = 1'b0;
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL gap_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL gap_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_reset_pending;
    int  s;
    ev_t e, o;
    idle_load(4, 0);
    s  = cyc;
    en = 1'b1;
    exp_q.push_back(mk(s + 4, 1));
    exp_q.push_back(mk(s + 8, 2));
    exp_q.push_back(mk(s + 39, 1));
    exp_q.push_back(mk(s + 66, 2));
    for (int c = 1; c <= 71; c++) begin
      @(negedge clk);
      if (c == 9) begin
        div_int  = DIV_W'(6);
        div_load = 1'b1;
      end
      if (c == 10) begin
        div_load = 1'b0;
        n_cmp++;
        if (load_pending !== 1'b1) begin
          n_bad++;
          $display("FAIL rp_pend_before: got %b want 1", load_pending);
        end
      end
      if (c == 11) reset = 1'b1;
      if (c == 12) begin
        reset = 1'b0;
        n_cmp++;
        if ({load_pending, sample_tick, mid_tick, bit_tick, ovs_phase} !== 6'b0) begin
          n_bad++;
          $display("FAIL rp_outputs: got %b%b%b%b ph=%0d want all 0",
                   load_pending, sample_tick, mid_tick, bit_tick, ovs_phase);
        end
      end
      if (c == 68) en = 1'b0;
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rp_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  task automatic test_div_zero;
    int  s;
    ev_t e, o;
    idle_load(0, 0);
    s  = cyc;
    en = 1'b1;
    for (int k = 1; k <= 12; k++) exp_q.push_back(mk(s + k, k));
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 12) en = 1'b0;
    end
    #1;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL zero_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL zero_tick: got c=%0d st=%b ph=%0d md=%b bt=%b want c=%0d ph=%0d md=%b bt=%b",
                 o.c - s, o.st, o.ph, o.md, o.bt, e.c - s, e.ph, e.md, e.bt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_load_pending(1'b0);
    test_load_pending(1'b1);
    test_wrap_load();
    test_en_gap();
    test_reset_pending();
    test_div_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
